// File: rtl/bram_dual_arbiter.sv
// bram_dual_arbiter: shares one simple dual-port BRAM between requesters A and B
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   {a,b}_req_i/we_i/addr_i/data_i command valid, write select, address, write data
//   {a,b}_gnt_o                    command accepted this cycle (combinational)
//   {a,b}_rvalid_o                 rdata_o carries this requester's read result
//   rdata_o                        registered read-return data
//   mem_write_o/waddr_o/data_o     registered RAM write command
//   mem_raddr_o                    registered RAM read address
//   mem_data_i                     RAM read data (RAM registers it on negedge)
module bram_dual_arbiter #(
    parameter int memSize_p   = 8,
    parameter int dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   a_req_i,
    input  logic                   a_we_i,
    input  logic [memSize_p-1:0]   a_addr_i,
    input  logic [dataWidth_p-1:0] a_data_i,
    output logic                   a_gnt_o,
    output logic                   a_rvalid_o,
    input  logic                   b_req_i,
    input  logic                   b_we_i,
    input  logic [memSize_p-1:0]   b_addr_i,
    input  logic [dataWidth_p-1:0] b_data_i,
    output logic                   b_gnt_o,
    output logic                   b_rvalid_o,
    output logic [dataWidth_p-1:0] rdata_o,
    output logic                   mem_write_o,
    output logic [memSize_p-1:0]   mem_waddr_o,
    output logic [memSize_p-1:0]   mem_raddr_o,
    output logic [dataWidth_p-1:0] mem_data_o,
    input  logic [dataWidth_p-1:0] mem_data_i
);
    logic a_rd, a_wr, b_rd, b_wr;
    logic a_rg, b_rg, a_wg, b_wg;
    // priority pointers: 0 favours A, 1 favours B
    logic rd_prio_q, rd_prio_d, wr_prio_q, wr_prio_d;
    logic mem_write_q, rd_vld_q, rd_own_q, a_rvalid_q, b_rvalid_q;
    logic [memSize_p-1:0]   waddr_q, raddr_q;
    logic [dataWidth_p-1:0] wdata_q, rdata_q;

    always_comb begin
        a_rd = a_req_i && !a_we_i;
        a_wr = a_req_i && a_we_i;
        b_rd = b_req_i && !b_we_i;
        b_wr = b_req_i && b_we_i;
        a_rg = rst_ni && a_rd && (!b_rd || !rd_prio_q);
        b_rg = rst_ni && b_rd && (!a_rd || rd_prio_q);
        a_wg = rst_ni && a_wr && (!b_wr || !wr_prio_q);
        b_wg = rst_ni && b_wr && (!a_wr || wr_prio_q);
        // on contention the pointer moves to the loser: B loses exactly when A wins
        rd_prio_d = (a_rd && b_rd) ? a_rg : rd_prio_q;
        wr_prio_d = (a_wr && b_wr) ? a_wg : wr_prio_q;
    end

    assign a_gnt_o     = a_rg || a_wg;
    assign b_gnt_o     = b_rg || b_wg;
    assign a_rvalid_o  = a_rvalid_q;
    assign b_rvalid_o  = b_rvalid_q;
    assign rdata_o     = rdata_q;
    assign mem_write_o = mem_write_q;
    assign mem_waddr_o = waddr_q;
    assign mem_raddr_o = raddr_q;
    assign mem_data_o  = wdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_prio_q   <= 1'b0;
            wr_prio_q   <= 1'b0;
            mem_write_q <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rd_vld_q    <= 1'b0;
            rd_own_q    <= 1'b0;
            rdata_q     <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
        end else begin
            rd_prio_q   <= rd_prio_d;
            wr_prio_q   <= wr_prio_d;
            mem_write_q <= a_wg || b_wg;
            if (a_wg || b_wg) begin
                waddr_q <= b_wg ? b_addr_i : a_addr_i;
                wdata_q <= b_wg ? b_data_i : a_data_i;
            end
            rd_vld_q <= a_rg || b_rg;
            if (a_rg || b_rg) begin
                raddr_q  <= b_rg ? b_addr_i : a_addr_i;
                rd_own_q <= b_rg;
            end
            // RAM output was registered at the negedge after the read command
            if (rd_vld_q) rdata_q <= mem_data_i;
            a_rvalid_q <= rd_vld_q && !rd_own_q;
            b_rvalid_q <= rd_vld_q && rd_own_q;
        end
    end
endmodule

// File: tb/tb_bram_dual_arbiter.sv
// tb_bram_dual_arbiter: directed plus random checks of bram_dual_arbiter against a word-level memory model
// Ports: none (top-level bench; drives the DUT and models the negedge-read RAM)
module tb_bram_dual_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          a_req_i = 1'b0, a_we_i = 1'b0, b_req_i = 1'b0, b_we_i = 1'b0;
    logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
    logic [DW-1:0] a_data_i = '0, b_data_i = '0;
    logic          a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, mem_write_o;
    logic [DW-1:0] rdata_o, mem_data_o, mem_data_i;
    logic [AW-1:0] mem_waddr_o, mem_raddr_o;

    int total = 0;
    int bad = 0;

    bram_dual_arbiter #(.memSize_p(AW), .dataWidth_p(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
        .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
        .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
        .rdata_o(rdata_o), .mem_write_o(mem_write_o), .mem_waddr_o(mem_waddr_o),
        .mem_raddr_o(mem_raddr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // behavioural BRAM: posedge write, negedge-registered read
    logic [DW-1:0] ram [2**AW] = '{default: '0};
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk_i) if (mem_write_o) ram[mem_waddr_o] <= mem_data_o;
    always @(negedge clk_i) ram_q <= ram[mem_raddr_o];
    assign mem_data_i = ram_q;

    // reference model: memory contents as seen by later reads, plus arbitration rules
    logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
    logic          rp = 1'b0, wp = 1'b0;
    logic          pend_v = 1'b0, pend_o = 1'b0;
    logic [DW-1:0] pend_d = '0, exp_rdata = '0, exp_wdata = '0;
    logic          exp_rva = 1'b0, exp_rvb = 1'b0, exp_mw = 1'b0;
    logic [AW-1:0] exp_waddr = '0, exp_raddr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_gnt(output logic ga, output logic gb);
        logic ar, aw, br, bw;
        ar = a_req_i && !a_we_i;
        aw = a_req_i && a_we_i;
        br = b_req_i && !b_we_i;
        bw = b_req_i && b_we_i;
        ga = rst_ni && ((ar && (!br || rp == 1'b0)) || (aw && (!bw || wp == 1'b0)));
        gb = rst_ni && ((br && (!ar || rp == 1'b1)) || (bw && (!aw || wp == 1'b1)));
    endtask

    // one clock: check outputs mid-cycle, advance the model on the edge, drop granted requests
    task automatic tick();
        logic ga, gb;
        @(negedge clk_i);
        model_gnt(ga, gb);
        chk("a_gnt", 32'(a_gnt_o), 32'(ga));
        chk("b_gnt", 32'(b_gnt_o), 32'(gb));
        chk("a_rvalid", 32'(a_rvalid_o), 32'(exp_rva));
        chk("b_rvalid", 32'(b_rvalid_o), 32'(exp_rvb));
        chk("rdata", 32'(rdata_o), 32'(exp_rdata));
        chk("mem_write", 32'(mem_write_o), 32'(exp_mw));
        chk("mem_raddr", 32'(mem_raddr_o), 32'(exp_raddr));
        if (exp_mw) begin
            chk("mem_waddr", 32'(mem_waddr_o), 32'(exp_waddr));
            chk("mem_wdata", 32'(mem_data_o), 32'(exp_wdata));
        end
        @(posedge clk_i);
        model_gnt(ga, gb);
        if (!rst_ni) begin
            rp = 0; wp = 0; pend_v = 0; exp_rva = 0; exp_rvb = 0;
            exp_rdata = '0; exp_mw = 0; exp_waddr = '0; exp_wdata = '0; exp_raddr = '0;
            ga = 0; gb = 0;
        end else begin
            exp_rva = pend_v && !pend_o;
            exp_rvb = pend_v && pend_o;
            if (pend_v) exp_rdata = pend_d;
            pend_v = 0;
            exp_mw = 0;
            // reads take the word before any same-edge write lands
            if (ga && !a_we_i) begin pend_v = 1; pend_o = 0; pend_d = ref_mem[a_addr_i]; exp_raddr = a_addr_i; end
            if (gb && !b_we_i) begin pend_v = 1; pend_o = 1; pend_d = ref_mem[b_addr_i]; exp_raddr = b_addr_i; end
            if (ga && a_we_i) begin ref_mem[a_addr_i] = a_data_i; exp_mw = 1; exp_waddr = a_addr_i; exp_wdata = a_data_i; end
            if (gb && b_we_i) begin ref_mem[b_addr_i] = b_data_i; exp_mw = 1; exp_waddr = b_addr_i; exp_wdata = b_data_i; end
            if (a_req_i && b_req_i && a_we_i == b_we_i) begin
                if (a_we_i) wp = gb ? 1'b0 : 1'b1;
                else rp = gb ? 1'b0 : 1'b1;
            end
        end
        #1;
        if (ga) a_req_i = 0;
        if (gb) b_req_i = 0;
    endtask

    task automatic set_a(input logic req, input logic we, input int addr, input int data);
        a_req_i = req; a_we_i = we; a_addr_i = AW'(addr); a_data_i = DW'(data);
    endtask

    task automatic set_b(input logic req, input logic we, input int addr, input int data);
        b_req_i = req; b_we_i = we; b_addr_i = AW'(addr); b_data_i = DW'(data);
    endtask

    initial begin
        // reset held with both requesters asking
        set_a(1, 0, 'h00, 0); set_b(1, 0, 'h00, 0);
        @(posedge clk_i); #1;
        repeat (3) tick();
        rst_ni = 1;
        // both contend for the read class, then the write class: A first each time
        tick(); tick();
        set_a(1, 1, 'h30, 'hA0A0); set_b(1, 1, 'h31, 'hB0B0);
        tick(); tick();
        // A write then read back
        set_a(1, 1, 'h10, 'hBEEF); tick();
        set_a(1, 0, 'h10, 0); tick();
        tick(); tick();
        // seed two words, then contended reads held for four cycles
        set_a(1, 1, 'h01, 'h1111); set_b(1, 1, 'h02, 'h2222); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            set_a(1, 0, 'h01, 0); set_b(1, 0, 'h02, 0); tick();
        end
        tick(); tick();
        // same-edge write/read to one address, then re-read
        set_a(1, 1, 'h20, 'h5555); set_b(1, 0, 'h20, 0); tick();
        set_b(1, 0, 'h20, 0); tick();
        tick(); tick();
        // read accepted just before a reset edge
        set_a(1, 0, 'h10, 0); tick();
        rst_ni = 0; tick();
        rst_ni = 1; tick(); tick();
        // top address
        set_a(1, 1, 'hFF, 'hCAFE); tick();
        set_b(1, 0, 'hFF, 0); tick();
        tick(); tick();
        // random traffic; a pending request is held until the model grants it
        for (int i = 0; i < 600; i++) begin
            if (!a_req_i) set_a($urandom_range(0, 9) < 7, 1'($urandom), int'($urandom_range(0, 15)), int'($urandom));
            if (!b_req_i) set_b($urandom_range(0, 9) < 7, 1'($urandom), int'($urandom_range(0, 15)), int'($urandom));
            tick();
        end
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        tick(); tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
